return_stack: RTL and testbench
===============================

# return_stack

Hardware call/return stack that completes the program counter's jump path. On each call it stores the return address that the PC saves when it takes a jump. On each return it pops that address and drives the PC's jump inputs, so execution resumes after the call site. It sits beside the PC: its inputs come from the decoder and the PC stack output, and its outputs feed the PC jump-address and jump-signal inputs.

## Interface
- `DEPTH`, default 8: number of stored return addresses; must be ≥ 2.
- `ADDR_W`, default 8: address width; matches the PC.
- `i_Timming` in, 1: clock; all state updates on its rising edge.
- `i_Rst` in, 1: reset, synchronous, active-high.
- `i_Push` in, 1: call executed this cycle; store `i_Push_Dir`.
- `i_Push_Dir` in, ADDR_W: address to save, driven from the PC stack output.
- `i_Pop` in, 1: return executed this cycle; pop and jump.
- `o_Senal_de_salto` out, 1: one-cycle jump request to the PC.
- `o_Direccion_salto` out, ADDR_W: jump target, valid while `o_Senal_de_salto` = 1.
- `o_Nivel` out, $clog2(DEPTH+1): current number of entries.
- `o_Lleno` out, 1: `o_Nivel` == DEPTH.
- `o_Vacio` out, 1: `o_Nivel` == 0.
- `o_Error` out, 1: sticky overflow/underflow flag (see Configuration).

## Operation
- The stack is a LIFO of DEPTH entries with a level counter `nivel` (0..DEPTH). The top entry is at index `nivel`-1.
- **Push only, not full:** write `i_Push_Dir` at index `nivel`; `nivel` += 1.
- **Push only, full:** overflow. The write is dropped and `nivel` is unchanged.
- **Pop only, not empty:** read the top entry `t`; `nivel` -= 1. Next cycle, assert `o_Senal_de_salto` = 1 with `o_Direccion_salto` = `t` + 1, mod 2^ADDR_W. 8'hFF returns to 8'h00.
- **Pop only, empty:** underflow. No jump; `o_Senal_de_salto` stays 0 and `nivel` stays 0.
- **Push and pop together, not empty:** the pop is performed first. The jump target is the old top + 1, and the top entry is then overwritten with `i_Push_Dir`. `nivel` is unchanged. This holds when full as well, with no overflow.
- **Push and pop together, empty:** underflow on the pop, then the push executes; `nivel` becomes 1.
- `o_Lleno` and `o_Vacio` are decoded combinationally from the `nivel` register.

## Timing
- Reset values: `o_Senal_de_salto` 0, `o_Direccion_salto` 0, `o_Nivel` 0, `o_Vacio` 1, `o_Lleno` 0, `o_Error` 0. Stack contents are don't-care.
- Reset has priority over push and pop in the same cycle. A jump pulse that would have appeared the cycle after reset is cancelled.
- Pop-to-jump latency is exactly 1 cycle. The pulse is exactly 1 cycle wide. Pops on consecutive cycles give back-to-back pulses with successive targets.
- `o_Nivel`, `o_Lleno` and `o_Vacio` reflect a push or pop in the cycle after it is sampled.
- A value pushed in cycle N can be popped in cycle N+1.

## Configuration
- Macro: `RETURN_STACK_ERR_EN`.
- **Defined:** `o_Error` is set on any overflow or underflow and holds until `i_Rst`.
- **Undefined:** `o_Error` is tied to 0 and no error logic is built. Overflow and underflow handling is identical in both builds.

## Structure
- Package `return_stack_pkg` holds:
  - the `ADDR_W` default constant;
  - typedef `addr_t` (logic [ADDR_W-1:0]).
- One sub-module, `lifo_mem`: a DEPTH × ADDR_W register array with one synchronous write port and one combinational read port at index `nivel`-1.
- Pointer control, the jump register and the error flag live in `return_stack`.

## Test plan
- Reset, then idle → `o_Vacio`=1, `o_Nivel`=0, `o_Senal_de_salto`=0, `o_Error`=0.
- Push 8'h10, 8'h20, 8'h30, then pop ×3 on consecutive cycles → pulses on 3 consecutive cycles with targets 8'h31, 8'h21, 8'h11; ends with `o_Vacio`=1.
- DEPTH=8: push 9 values 8'h00..8'h08 → `o_Lleno`=1, `o_Nivel`=8, `o_Error`=1 (macro on). Then pop → target 8'h08.
- Pop when empty → no pulse, `o_Nivel`=0. `o_Error`=1 with macro on, stays 0 with macro off.
- With 8'h40 on top, push 8'h55 and pop in the same cycle → target 8'h41, `o_Nivel` unchanged. Then pop → target 8'h56.
- Push 8'hFF, pop with `i_Rst` asserted in the cycle after the pop → no pulse, all outputs at reset values. Separately, push 8'hFF then pop without reset → target 8'h00.

Source files
------------

// File: rtl/return_stack_pkg.sv
// Shared types and defaults for the call/return stack beside the PC.
// Address width default must track the PC's address width.
package return_stack_pkg;

    localparam int ADDR_W_DEFAULT = 8;

    typedef logic [ADDR_W_DEFAULT-1:0] addr_t;

endpackage

// File: rtl/return_stack_if.sv
// Decoder/PC-facing bundle of the return stack: call/return strobes in, jump request and status out.
// The slave modport is the stack itself; the master modport is the decoder/PC side.
interface return_stack_if
    import return_stack_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int NW     = 4
) ();

    logic              i_Push;
    logic [ADDR_W-1:0] i_Push_Dir;
    logic              i_Pop;
    logic              o_Senal_de_salto;
    logic [ADDR_W-1:0] o_Direccion_salto;
    logic [NW-1:0]     o_Nivel;
    logic              o_Lleno;
    logic              o_Vacio;
    logic              o_Error;

    modport master (
        output i_Push, i_Push_Dir, i_Pop,
        input  o_Senal_de_salto, o_Direccion_salto, o_Nivel, o_Lleno, o_Vacio, o_Error
    );

    modport slave (
        input  i_Push, i_Push_Dir, i_Pop,
        output o_Senal_de_salto, o_Direccion_salto, o_Nivel, o_Lleno, o_Vacio, o_Error
    );

endinterface

// File: rtl/return_stack_lifo_mem.sv
// Return-address storage: DEPTH x ADDR_W registers, one synchronous write port,
// one combinational read port returning the top entry (index nivel-1, zero when empty).
module lifo_mem
    import return_stack_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int NW     = $clog2(DEPTH + 1),
    parameter int IW     = $clog2(DEPTH)
) (
    input  logic              i_Timming,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_idx,
    input  logic [ADDR_W-1:0] wr_dat,
    input  logic [NW-1:0]     nivel,
    output logic [ADDR_W-1:0] top_dat
);

    logic [ADDR_W-1:0] mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge i_Timming) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    always_comb begin
        top_dat = '0;
        if (nivel != '0) begin
            top_dat = mem[IW'(nivel - 1'b1)];
        end
    end

endmodule

// File: rtl/return_stack.sv
// Call/return stack feeding the PC jump inputs; pop-to-jump latency 1 cycle, no backpressure.
// Optional sticky overflow/underflow flag built only with RETURN_STACK_ERR_EN defined.
module return_stack
    import return_stack_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int NW     = $clog2(DEPTH + 1),
    parameter int IW     = $clog2(DEPTH)
) (
    input  logic          i_Timming,
    input  logic          i_Rst,
    return_stack_if.slave rs
);

    logic [NW-1:0]     nivel_q;
    logic [NW-1:0]     nivel_d;
    logic              vacio;
    logic              lleno;
    logic              pop_ok;
    logic              push_ok;
    logic [IW-1:0]     wr_idx;
    logic [ADDR_W-1:0] top_dat;
    logic              salto_q;
    logic [ADDR_W-1:0] dir_q;

    assign vacio = (nivel_q == '0);
    assign lleno = (nivel_q == NW'(DEPTH));

    // A pop frees the top slot first, so a simultaneous push is never an overflow.
    assign pop_ok  = rs.i_Pop & ~vacio;
    assign push_ok = rs.i_Push & (~lleno | pop_ok);
    assign wr_idx  = pop_ok ? IW'(nivel_q - 1'b1) : IW'(nivel_q);

    always_comb begin
        nivel_d = nivel_q;
        if (push_ok && !pop_ok) begin
            nivel_d = nivel_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            nivel_d = nivel_q - 1'b1;
        end
    end

    lifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .NW     (NW),
        .IW     (IW)
    ) u_mem (
        .i_Timming (i_Timming),
        .wr_en     (push_ok),
        .wr_idx    (wr_idx),
        .wr_dat    (rs.i_Push_Dir),
        .nivel     (nivel_q),
        .top_dat   (top_dat)
    );

    always_ff @(posedge i_Timming) begin
        if (i_Rst) begin
            nivel_q <= '0;
            salto_q <= 1'b0;
            dir_q   <= '0;
        end else begin
            nivel_q <= nivel_d;
            salto_q <= pop_ok;
            if (pop_ok) begin
                dir_q <= top_dat + 1'b1;
            end
        end
    end

`ifdef RETURN_STACK_ERR_EN
    logic err_q;

    always_ff @(posedge i_Timming) begin
        if (i_Rst) begin
            err_q <= 1'b0;
        end else if ((rs.i_Push && lleno && !pop_ok) || (rs.i_Pop && vacio)) begin
            err_q <= 1'b1;
        end
    end

    assign rs.o_Error = err_q;
`else
    assign rs.o_Error = 1'b0;
`endif

    // Reset also masks a pulse already registered, so a return caught by reset never reaches the PC.
    assign rs.o_Senal_de_salto  = salto_q & ~i_Rst;
    assign rs.o_Direccion_salto = i_Rst ? '0 : dir_q;
    assign rs.o_Nivel           = nivel_q;
    assign rs.o_Lleno           = lleno;
    assign rs.o_Vacio           = vacio;

endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack: directed scenarios plus a randomized run against a queue-based LIFO model.
module tb_return_stack;
    import return_stack_pkg::*;

    localparam int DEPTH = 8;
    localparam int NW    = $clog2(DEPTH + 1);
`ifdef RETURN_STACK_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    return_stack_if #(.ADDR_W(ADDR_W_DEFAULT), .NW(NW)) rs_if ();

    return_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W_DEFAULT)) dut (
        .i_Timming (clk),
        .i_Rst     (rst),
        .rs        (rs_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    addr_t m_stk[$];
    bit    m_pend;
    addr_t m_dir;
    bit    m_err;

    function automatic void model_edge(input bit r, input bit pu, input bit po, input addr_t d);
        addr_t t;
        if (r) begin
            m_stk.delete();
            m_pend = 1'b0;
            m_dir  = '0;
            m_err  = 1'b0;
        end else begin
            m_pend = 1'b0;
            if (po && m_stk.size() > 0) begin
                t      = m_stk.pop_back();
                m_pend = 1'b1;
                m_dir  = t + 8'd1;
                if (pu) m_stk.push_back(d);
            end else begin
                if (po) m_err = 1'b1;
                if (pu) begin
                    if (m_stk.size() < DEPTH) m_stk.push_back(d);
                    else m_err = 1'b1;
                end
            end
        end
    endfunction

    // Drive inputs for one cycle, clock them in, and land on the following falling edge.
    task automatic step(input bit r, input bit pu, input bit po, input addr_t d);
        rst               = r;
        rs_if.i_Push      = pu;
        rs_if.i_Pop       = po;
        rs_if.i_Push_Dir  = d;
        @(posedge clk);
        model_edge(r, pu, po, d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        total++; if (rs_if.o_Vacio !== 1'b1) begin bad++; $display("FAIL reset_vacio got=%0b exp=1", rs_if.o_Vacio); end
        total++; if (rs_if.o_Nivel !== NW'(0)) begin bad++; $display("FAIL reset_nivel got=%0d exp=0", rs_if.o_Nivel); end
        total++; if (rs_if.o_Senal_de_salto !== 1'b0) begin bad++; $display("FAIL reset_salto got=%0b exp=0", rs_if.o_Senal_de_salto); end
        total++; if (rs_if.o_Direccion_salto !== 8'h00) begin bad++; $display("FAIL reset_dir got=%h exp=00", rs_if.o_Direccion_salto); end
        total++; if (rs_if.o_Lleno !== 1'b0) begin bad++; $display("FAIL reset_lleno got=%0b exp=0", rs_if.o_Lleno); end
        total++; if (rs_if.o_Error !== 1'b0) begin bad++; $display("FAIL reset_error got=%0b exp=0", rs_if.o_Error); end
    endtask

    task automatic test_lifo_order();
        addr_t exp_t [3];
        exp_t[0] = 8'h31; exp_t[1] = 8'h21; exp_t[2] = 8'h11;
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'h10);
        step(0, 1, 0, 8'h20);
        step(0, 1, 0, 8'h30);
        total++; if (rs_if.o_Nivel !== NW'(3)) begin bad++; $display("FAIL lifo_nivel3 got=%0d exp=3", rs_if.o_Nivel); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 8'h00);
            total++; if (rs_if.o_Senal_de_salto !== 1'b1) begin bad++; $display("FAIL lifo_pulse%0d got=%0b exp=1", i, rs_if.o_Senal_de_salto); end
            total++; if (rs_if.o_Direccion_salto !== exp_t[i]) begin bad++; $display("FAIL lifo_target%0d got=%h exp=%h", i, rs_if.o_Direccion_salto, exp_t[i]); end
        end
        total++; if (rs_if.o_Vacio !== 1'b1) begin bad++; $display("FAIL lifo_vacio got=%0b exp=1", rs_if.o_Vacio); end
        step(0, 0, 0, 8'h00);
        total++; if (rs_if.o_Senal_de_salto !== 1'b0) begin bad++; $display("FAIL lifo_pulse_end got=%0b exp=0", rs_if.o_Senal_de_salto); end
    endtask

    task automatic test_overflow();
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 9; i++) step(0, 1, 0, addr_t'(i));
        total++; if (rs_if.o_Lleno !== 1'b1) begin bad++; $display("FAIL ovf_lleno got=%0b exp=1", rs_if.o_Lleno); end
        total++; if (rs_if.o_Nivel !== NW'(8)) begin bad++; $display("FAIL ovf_nivel got=%0d exp=8", rs_if.o_Nivel); end
        total++; if (rs_if.o_Error !== ERR_ON) begin bad++; $display("FAIL ovf_error got=%0b exp=%0b", rs_if.o_Error, ERR_ON); end
        step(0, 0, 1, 8'h00);
        total++; if (rs_if.o_Direccion_salto !== 8'h08 || rs_if.o_Senal_de_salto !== 1'b1) begin
            bad++; $display("FAIL ovf_pop_target got=%h/%0b exp=08/1", rs_if.o_Direccion_salto, rs_if.o_Senal_de_salto);
        end
        total++; if (rs_if.o_Error !== ERR_ON) begin bad++; $display("FAIL ovf_error_sticky got=%0b exp=%0b", rs_if.o_Error, ERR_ON); end
    endtask

    task automatic test_underflow();
        step(1, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        total++; if (rs_if.o_Senal_de_salto !== 1'b0) begin bad++; $display("FAIL unf_salto got=%0b exp=0", rs_if.o_Senal_de_salto); end
        total++; if (rs_if.o_Nivel !== NW'(0)) begin bad++; $display("FAIL unf_nivel got=%0d exp=0", rs_if.o_Nivel); end
        total++; if (rs_if.o_Error !== ERR_ON) begin bad++; $display("FAIL unf_error got=%0b exp=%0b", rs_if.o_Error, ERR_ON); end
        // Pop while empty together with a push: only the push takes effect.
        step(1, 0, 0, 8'h00);
        step(0, 1, 1, 8'h77);
        total++; if (rs_if.o_Nivel !== NW'(1) || rs_if.o_Senal_de_salto !== 1'b0) begin
            bad++; $display("FAIL unf_pushpop got=%0d/%0b exp=1/0", rs_if.o_Nivel, rs_if.o_Senal_de_salto);
        end
        step(0, 0, 1, 8'h00);
        total++; if (rs_if.o_Direccion_salto !== 8'h78) begin bad++; $display("FAIL unf_pushpop_target got=%h exp=78", rs_if.o_Direccion_salto); end
    endtask

    task automatic test_push_pop_same();
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'h40);
        step(0, 1, 1, 8'h55);
        total++; if (rs_if.o_Direccion_salto !== 8'h41 || rs_if.o_Senal_de_salto !== 1'b1) begin
            bad++; $display("FAIL pp_target got=%h/%0b exp=41/1", rs_if.o_Direccion_salto, rs_if.o_Senal_de_salto);
        end
        total++; if (rs_if.o_Nivel !== NW'(1)) begin bad++; $display("FAIL pp_nivel got=%0d exp=1", rs_if.o_Nivel); end
        step(0, 0, 1, 8'h00);
        total++; if (rs_if.o_Direccion_salto !== 8'h56) begin bad++; $display("FAIL pp_second got=%h exp=56", rs_if.o_Direccion_salto); end
    endtask

    task automatic test_reset_cancel();
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'hFF);
        rs_if.i_Push = 1'b0; rs_if.i_Pop = 1'b1;
        @(posedge clk);
        model_edge(0, 0, 1, 8'h00);
        #1;
        rst = 1'b1; rs_if.i_Pop = 1'b0;
        #1;
        total++; if (rs_if.o_Senal_de_salto !== 1'b0) begin bad++; $display("FAIL rc_masked got=%0b exp=0", rs_if.o_Senal_de_salto); end
        total++; if (rs_if.o_Direccion_salto !== 8'h00) begin bad++; $display("FAIL rc_dir got=%h exp=00", rs_if.o_Direccion_salto); end
        @(posedge clk);
        model_edge(1, 0, 0, 8'h00);
        @(negedge clk);
        total++; if (rs_if.o_Senal_de_salto !== 1'b0 || rs_if.o_Nivel !== NW'(0) || rs_if.o_Vacio !== 1'b1 ||
                     rs_if.o_Lleno !== 1'b0 || rs_if.o_Error !== 1'b0 || rs_if.o_Direccion_salto !== 8'h00) begin
            bad++; $display("FAIL rc_all_reset got salto=%0b nivel=%0d vacio=%0b lleno=%0b err=%0b dir=%h",
                            rs_if.o_Senal_de_salto, rs_if.o_Nivel, rs_if.o_Vacio, rs_if.o_Lleno, rs_if.o_Error, rs_if.o_Direccion_salto);
        end
        // Pop sampled in the same cycle as reset produces no pulse.
        step(0, 1, 0, 8'hFF);
        step(1, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);
        total++; if (rs_if.o_Senal_de_salto !== 1'b0) begin bad++; $display("FAIL rc_same_cycle got=%0b exp=0", rs_if.o_Senal_de_salto); end
        step(0, 1, 0, 8'hFF);
        step(0, 0, 1, 8'h00);
        total++; if (rs_if.o_Direccion_salto !== 8'h00 || rs_if.o_Senal_de_salto !== 1'b1) begin
            bad++; $display("FAIL rc_wrap got=%h/%0b exp=00/1", rs_if.o_Direccion_salto, rs_if.o_Senal_de_salto);
        end
    endtask

    task automatic test_random();
        bit r, pu, po;
        int push_pct;
        step(1, 0, 0, 8'h00);
        for (int c = 0; c < 600; c++) begin
            push_pct = ((c / 100) % 2 == 0) ? 75 : 25;
            r  = ($urandom_range(0, 59) == 0);
            pu = ($urandom_range(0, 99) < push_pct);
            po = ($urandom_range(0, 99) < (100 - push_pct));
            step(r, pu, po, addr_t'($urandom));
            total++; if (rs_if.o_Senal_de_salto !== m_pend) begin bad++; $display("FAIL rnd_salto c=%0d got=%0b exp=%0b", c, rs_if.o_Senal_de_salto, m_pend); end
            if (m_pend) begin
                total++; if (rs_if.o_Direccion_salto !== m_dir) begin bad++; $display("FAIL rnd_dir c=%0d got=%h exp=%h", c, rs_if.o_Direccion_salto, m_dir); end
            end
            total++; if (rs_if.o_Nivel !== NW'(m_stk.size())) begin bad++; $display("FAIL rnd_nivel c=%0d got=%0d exp=%0d", c, rs_if.o_Nivel, m_stk.size()); end
            total++; if (rs_if.o_Vacio !== (m_stk.size() == 0)) begin bad++; $display("FAIL rnd_vacio c=%0d got=%0b", c, rs_if.o_Vacio); end
            total++; if (rs_if.o_Lleno !== (m_stk.size() == DEPTH)) begin bad++; $display("FAIL rnd_lleno c=%0d got=%0b", c, rs_if.o_Lleno); end
            total++; if (rs_if.o_Error !== (m_err & ERR_ON)) begin bad++; $display("FAIL rnd_error c=%0d got=%0b exp=%0b", c, rs_if.o_Error, m_err & ERR_ON); end
        end
    endtask

    initial begin
        rs_if.i_Push     = 1'b0;
        rs_if.i_Pop      = 1'b0;
        rs_if.i_Push_Dir = '0;
        m_pend = 1'b0;
        m_dir  = '0;
        m_err  = 1'b0;
        test_reset();
        test_lifo_order();
        test_overflow();
        test_underflow();
        test_push_pop_same();
        test_reset_cancel();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
